// File: rtl/fdiv_pkg.sv
// Shared constants, operand classes and IEEE special-case resolution for fdiv_unit.
package fdiv_pkg;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  localparam logic [31:0] PINF = 32'h7F80_0000;

  // Bit positions inside the 2-bit {NV, DZ} flag field.
  localparam int FLAG_NV = 1;
  localparam int FLAG_DZ = 0;

  typedef enum logic [1:0] {
    ZERO,
    NORM,
    INF,
    NAN
  } fclass_t;

  // Result of the issue-time special-case check.
  typedef struct packed {
    logic        hit;
    logic [31:0] y;
    logic [1:0]  flags;
  } special_t;

  // Exponent 0 is treated as zero, so denormals flush to zero.
  function automatic fclass_t classify(input logic [31:0] x);
    if (x[30:23] == 8'h00) begin
      return ZERO;
    end else if (x[30:23] == 8'hFF) begin
      return (x[22:0] == 23'd0) ? INF : NAN;
    end else begin
      return NORM;
    end
  endfunction

  // Resolves the operand pairs the core datapath cannot handle, in priority order.
  function automatic special_t resolve_special(input logic [31:0] x1, input logic [31:0] x2);
    fclass_t  c1;
    fclass_t  c2;
    logic     s;
    special_t r;
    c1 = classify(x1);
    c2 = classify(x2);
    s  = x1[31] ^ x2[31];
    r  = '{hit: 1'b1, y: QNAN, flags: 2'b00};
    if (c1 == NAN || c2 == NAN) begin
      r.y = QNAN;
    end else if ((c1 == ZERO && c2 == ZERO) || (c1 == INF && c2 == INF)) begin
      r.y              = QNAN;
      r.flags[FLAG_NV] = 1'b1;
    end else if (c2 == ZERO && c1 == NORM) begin
      r.y              = {s, PINF[30:0]};
      r.flags[FLAG_DZ] = 1'b1;
    end else if (c1 == INF) begin
      r.y = {s, PINF[30:0]};
    end else if (c2 == INF || c1 == ZERO) begin
      r.y = {s, 31'd0};
    end else begin
      r.hit = 1'b0;
      r.y   = 32'd0;
    end
    return r;
  endfunction

endpackage

// File: rtl/fdiv.sv
// Non-stallable single-precision divide datapath for normal operands only.
// Stage 1 forms the mantissa quotient, stage 2 normalises/rounds/packs,
// the remaining stages are pure delay to reach LATENCY cycles.
module fdiv
  import fdiv_pkg::*;
#(
  parameter int LATENCY = 7
) (
  input  logic        clk,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  output logic [31:0] y
);

  logic [48:0]       num;
  logic [48:0]       den;
  logic [25:0]       quo;
  logic [23:0]       rem;

  logic              s1_sign;
  logic signed [9:0] s1_exp;
  logic [25:0]       s1_q;
  logic              s1_rem_nz;

  logic signed [9:0] norm_e;
  logic [23:0]       mant;
  logic              guard;
  logic              sticky;
  logic [24:0]       mant_r;
  logic [22:0]       frac;
  logic [31:0]       y2;

  logic [31:0]       dly [LATENCY-1];

  // Quotient of 1.m mantissas lies in (0.5, 2), so 25 extra dividend bits give
  // 24 result bits plus guard, with the remainder folded into sticky.
  assign num = {1'b1, x1[22:0], 25'd0};
  assign den = {25'd0, 1'b1, x2[22:0]};
  assign quo = 26'(num / den);
  assign rem = 24'(num % den);

  // NOTE: the datapath carries no reset; the surrounding valid pipeline decides
  // which results are real, so stale contents are harmless.
  // Stage 1: register quotient, remainder-nonzero, sign and biased exponent.
  always_ff @(posedge clk) begin
    s1_sign   <= x1[31] ^ x2[31];
    s1_exp    <= $signed({2'b00, x1[30:23]}) - $signed({2'b00, x2[30:23]}) + 10'sd127;
    s1_q      <= quo;
    s1_rem_nz <= (rem != 24'd0);
  end

  // Stage 2 logic: normalise, round to nearest even, saturate and pack.
  always_comb begin
    norm_e = s1_exp - 10'sd1;
    mant   = s1_q[24:1];
    guard  = s1_q[0];
    sticky = s1_rem_nz;
    if (s1_q[25]) begin
      norm_e = s1_exp;
      mant   = s1_q[25:2];
      guard  = s1_q[1];
      sticky = s1_q[0] | s1_rem_nz;
    end
    mant_r = {1'b0, mant} + {24'd0, guard & (sticky | mant[0])};
    frac   = mant_r[22:0];
    if (mant_r[24]) begin
      norm_e = norm_e + 10'sd1;
      frac   = mant_r[23:1];
    end
    if (norm_e > 10'sd254) begin
      y2 = {s1_sign, PINF[30:0]};
    end else if (norm_e < 10'sd1) begin
      y2 = {s1_sign, 31'd0};
    end else begin
      y2 = {s1_sign, norm_e[7:0], frac};
    end
  end

  // Stage 2 register followed by the delay stages that pad out LATENCY.
  always_ff @(posedge clk) begin
    dly[0] <= y2;
    for (int i = 1; i < LATENCY - 1; i++) begin
      dly[i] <= dly[i-1];
    end
  end

  assign y = dly[LATENCY-2];

endmodule

// File: rtl/fdiv_resp_fifo.sv
// Synchronous response FIFO; the head entry drives the outputs and reads zero when empty.
module fdiv_resp_fifo #(
  parameter int W     = 39,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [AW:0]  count;

  // NOTE: storage is not reset; an entry is only visible once the write pointer
  // has passed it, and the head is masked to zero while empty.
  // Write the pushed entry at the tail slot.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  // Pointers carry one wrap bit so full and empty are distinguishable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign count = wr_ptr - rd_ptr;
  assign empty = (count == '0);
  assign head  = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/fdiv_unit.sv
// Issue/response wrapper around fdiv: special-case resolution at issue, a valid
// pipeline matching the core latency, and a credit-protected response FIFO.
module fdiv_unit
  import fdiv_pkg::*;
#(
  parameter int LATENCY    = 7,
  parameter int FIFO_DEPTH = 8,
  parameter int TAG_W      = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_x1,
  input  logic [31:0]      in_x2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_y,
  output logic [TAG_W-1:0] out_tag,
  output logic [1:0]       out_flags
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int RW = 32 + TAG_W + 2;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic             hit;
    logic [31:0]      y;
    logic [1:0]       flags;
  } stage_t;

  typedef struct packed {
    logic [31:0]      y;
    logic [TAG_W-1:0] tag;
    logic [1:0]       flags;
  } resp_t;

  logic          accept;
  logic          pop;
  logic [CW-1:0] outstanding;
  special_t      sp;
  logic [31:0]   core_y;
  stage_t        pipe [LATENCY];
  stage_t        tail;
  resp_t         tail_resp;
  resp_t         head;
  logic          fifo_empty;

  assign accept = in_valid && in_ready;
  assign pop    = out_valid && out_ready;

  // Credits only look at the registered count, so in_ready never depends on out_ready.
  assign in_ready = !rst && (outstanding < CW'(FIFO_DEPTH));

  assign sp = resolve_special(in_x1, in_x2);

  fdiv #(
    .LATENCY (LATENCY)
  ) u_fdiv (
    .clk (clk),
    .x1  (in_x1),
    .x2  (in_x2),
    .y   (core_y)
  );

  // Side-band pipeline travelling in lockstep with the core; only valid bits matter after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        pipe[i] <= '0;
      end
    end else begin
      pipe[0] <= '{valid: accept, tag: in_tag, hit: sp.hit, y: sp.y, flags: sp.flags};
      for (int i = 1; i < LATENCY; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign tail      = pipe[LATENCY-1];
  assign tail_resp = '{y: tail.hit ? tail.y : core_y, tag: tail.tag, flags: tail.flags};

  // In-flight plus buffered count; a same-cycle accept and pop cancel out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding <= '0;
    end else if (accept && !pop) begin
      outstanding <= outstanding + CW'(1);
    end else if (!accept && pop) begin
      outstanding <= outstanding - CW'(1);
    end
  end

  fdiv_resp_fifo #(
    .W     (RW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tail.valid),
    .push_data (tail_resp),
    .pop       (pop),
    .head      (head),
    .empty     (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign out_y     = head.y;
  assign out_tag   = head.tag;
  assign out_flags = head.flags;

endmodule

// File: tb/tb_fdiv_unit.sv
// Directed and randomised-backpressure bench for fdiv_unit with an in-order scoreboard.
module tb_fdiv_unit;

  localparam int TAG_W = 5;
  localparam int DEPTH = 8;
  localparam int NVEC  = 16;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_x1;
  logic [31:0]      in_x2;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_y;
  logic [TAG_W-1:0] out_tag;
  logic [1:0]       out_flags;

  fdiv_unit #(
    .LATENCY    (7),
    .FIFO_DEPTH (DEPTH),
    .TAG_W      (TAG_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x1     (in_x1),
    .in_x2     (in_x2),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_tag   (out_tag),
    .out_flags (out_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] x1;
    logic [31:0] x2;
    logic [31:0] y;
    logic [1:0]  flags;
  } vec_t;

  typedef struct packed {
    logic [31:0]      y;
    logic [TAG_W-1:0] tag;
    logic [1:0]       flags;
  } exp_t;

  vec_t        tbl [NVEC];
  exp_t        sb [$];
  int          n_cmp;
  int          n_bad;
  int          n_resp;
  int          model_out;
  int          cur;
  bit          last_acc;
  bit          ov;
  int          snap_count;
  bit          snap_irdy;
  bit          prev_stall;
  logic [31:0] prev_y;
  logic [TAG_W-1:0] prev_tag;
  logic [1:0]  prev_flags;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic drive(input int idx, input int tag);
    in_valid = 1'b1;
    in_x1    = tbl[idx].x1;
    in_x2    = tbl[idx].x2;
    in_tag   = TAG_W'(tag);
    cur      = idx;
  endtask

  // One clock: sample at the falling edge, score handshakes, then step past the rising edge.
  task automatic tick();
    exp_t e;
    bit   acc;
    bit   pp;
    @(negedge clk);
    acc        = in_valid && in_ready;
    pp         = out_valid && out_ready;
    ov         = out_valid;
    snap_count = int'(dut.u_fifo.count);
    snap_irdy  = in_ready;
    check("credit_ready", in_ready, (model_out < DEPTH));
    check("outstanding", dut.outstanding, model_out);
    if (prev_stall) begin
      check("stall_stable_y", out_y, prev_y);
      check("stall_stable_tag", out_tag, prev_tag);
      check("stall_stable_flags", out_flags, prev_flags);
    end
    if (pp) begin
      n_resp++;
      if (sb.size() == 0) begin
        check("unexpected_resp", out_valid, 1'b0);
      end else begin
        e = sb.pop_front();
        check("resp_y", out_y, e.y);
        check("resp_tag", out_tag, e.tag);
        check("resp_flags", out_flags, e.flags);
      end
    end
    if (acc) sb.push_back('{y: tbl[cur].y, tag: in_tag, flags: tbl[cur].flags});
    model_out  = model_out + int'(acc) - int'(pp);
    last_acc   = acc;
    prev_stall = out_valid && !out_ready;
    prev_y     = out_y;
    prev_tag   = out_tag;
    prev_flags = out_flags;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 64 && (sb.size() != 0 || model_out != 0); k++) tick();
    check("drain_left", sb.size(), 0);
    check("drain_out_valid", out_valid, 1'b0);
  endtask

  task automatic measure_latency(input int idx, input int tag);
    int n;
    out_ready = 1'b1;
    drive(idx, tag);
    tick();
    check("latency_accepted", last_acc, 1'b1);
    in_valid = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (!ov && n < 20);
    check("latency", n, 8);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int i;
    int base;
    tbl[0]  = '{32'h40C00000, 32'h40000000, 32'h40400000, 2'b00};
    tbl[1]  = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 2'b00};
    tbl[2]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 2'b00};
    tbl[3]  = '{32'h40400000, 32'h40800000, 32'h3F400000, 2'b00};
    tbl[4]  = '{32'hC1200000, 32'h40800000, 32'hC0200000, 2'b00};
    tbl[5]  = '{32'h3F800000, 32'h00000000, 32'h7F800000, 2'b01};
    tbl[6]  = '{32'h00000000, 32'h00000000, 32'h7FC00000, 2'b10};
    tbl[7]  = '{32'hFF800000, 32'h40000000, 32'hFF800000, 2'b00};
    tbl[8]  = '{32'h3F800000, 32'h7F800000, 32'h00000000, 2'b00};
    tbl[9]  = '{32'h7FC00000, 32'h3F800000, 32'h7FC00000, 2'b00};
    tbl[10] = '{32'h7F800000, 32'hFF800000, 32'h7FC00000, 2'b10};
    tbl[11] = '{32'h40000000, 32'h80000000, 32'hFF800000, 2'b01};
    tbl[12] = '{32'h00000001, 32'h3F800000, 32'h00000000, 2'b00};
    tbl[13] = '{32'h7F800000, 32'h00000000, 32'h7F800000, 2'b00};
    tbl[14] = '{32'h3F800000, 32'h7F800001, 32'h7FC00000, 2'b00};
    tbl[15] = '{32'h40C00000, 32'hC0000000, 32'hC0400000, 2'b00};

    n_cmp = 0; n_bad = 0; n_resp = 0; model_out = 0; cur = 0;
    prev_stall = 1'b0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_x1 = '0; in_x2 = '0; in_tag = '0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_y", out_y, 32'h0);
    check("rst_out_tag", out_tag, 5'h0);
    check("rst_out_flags", out_flags, 2'b00);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("in_ready_after_rst", in_ready, 1'b1);

    // First transaction: 6.0/2.0 tag 3 appears 8 cycles after accept.
    measure_latency(0, 3);
    drain();

    // Whole table back to back, normal and special operands.
    out_ready = 1'b1;
    for (int k = 0; k < NVEC; k++) begin
      drive(k, k);
      tick();
    end
    drain();

    // Backpressure: 20 requests against a stalled output.
    out_ready = 1'b0;
    i = 0;
    base = n_resp;
    for (int k = 0; k < 30; k++) begin
      drive(i % NVEC, i);
      tick();
      if (last_acc) i++;
    end
    check("accepts_before_stall", i, 8);
    check("in_ready_stalled", in_ready, 1'b0);
    out_ready = 1'b1;
    for (int k = 0; k < 200 && i < 20; k++) begin
      drive(i % NVEC, i);
      tick();
      if (last_acc) i++;
    end
    check("all_20_accepted", i, 20);
    drain();
    check("all_20_returned", n_resp - base, 20);

    // Tail push coinciding with a pop while all credits are in use.
    out_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      drive(k % 5, k + 8);
      tick();
    end
    in_valid = 1'b0;
    repeat (6) tick();
    out_ready = 1'b1;
    tick();
    check("full_pushpop_count_before", snap_count, 7);
    check("full_pushpop_in_ready", snap_irdy, 1'b0);
    tick();
    check("full_pushpop_count_after", snap_count, 7);
    drain();

    // Continuous issue against random backpressure.
    i = 0;
    for (int k = 0; k < 300; k++) begin
      out_ready = 1'($urandom_range(0, 1));
      drive(i % NVEC, i);
      tick();
      if (last_acc) i++;
    end
    drain();

    // Reset with 5 requests in flight and 3 buffered.
    out_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      drive(k, k + 16);
      tick();
    end
    in_valid = 1'b0;
    repeat (2) tick();
    check("buffered_before_rst", dut.u_fifo.count, 3);
    check("out_valid_before_rst", out_valid, 1'b1);
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_in_ready", in_ready, 1'b0);
    sb.delete();
    model_out  = 0;
    prev_stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    base = n_resp;
    repeat (20) tick();
    check("no_stale_resp", n_resp - base, 0);
    measure_latency(2, 9);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
